// File: rtl/keycode_sequencer_if.sv
// Script-entry write port of the keycode sequencer.
interface keycode_sequencer_if #(
    parameter int HOLD_W = 16
);
    // Handshake: an entry transfers on a rising clock edge where wr_valid and
    // wr_ready are both high. The producer keeps wr_valid and the payload
    // stable until that edge. wr_ready never depends on wr_valid.
    logic              wr_valid;
    logic              wr_ready;
    logic [2:0]        wr_slot;
    logic [7:0]        wr_keycode;
    logic [HOLD_W-1:0] wr_hold;
    logic              wr_release;

    modport master (
        output wr_valid, wr_slot, wr_keycode, wr_hold, wr_release,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_slot, wr_keycode, wr_hold, wr_release,
        output wr_ready
    );
endinterface

// File: rtl/keycode_sequencer.sv
// Keycode sequencer: buffers script entries in a FIFO and plays them back as
// HID keycodes on two 32-bit GPIO words, holding each key for a programmed
// number of cycles followed by a fixed release gap.
module keycode_sequencer #(
    parameter int NUM_SLOTS  = 6,
    parameter int DEPTH      = 16,
    parameter int HOLD_W     = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic                       clk_100MHz,
    input  logic                       reset_rtl_0,
    keycode_sequencer_if.slave         wr,
    input  logic                       run,
    output logic                       busy,
    output logic [31:0]                gpio_usb_keycode_0_tri_o,
    output logic [31:0]                gpio_usb_keycode_1_tri_o,
    output logic                       key_int,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err_slot,
    output logic [1:0]                 state_dbg
);
    localparam int          PTR_W       = $clog2(DEPTH);
    localparam int          CNT_W       = PTR_W + 1;
    localparam int          GAP_W       = $clog2(GAP_CYCLES + 1);
    localparam logic [3:0]  NUM_SLOTS_L = 4'(NUM_SLOTS);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // FIFO storage, one array per field
    logic [2:0]        mem_slot [DEPTH];
    logic [7:0]        mem_key  [DEPTH];
    logic [HOLD_W-1:0] mem_hold [DEPTH];
    logic              mem_rel  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              push, pop, err_set;

    state_t            state_q, state_n;
    logic [HOLD_W-1:0] hold_q, hold_n;
    logic [GAP_W-1:0]  gap_q, gap_n;
    logic              rel_q, rel_n;
    // Slot i occupies bits [8*i+7:8*i]; slots at or above NUM_SLOTS are never
    // written, so they stay zero from reset.
    logic [63:0]       keys_q, keys_n;

    logic [2:0]        head_slot;
    logic [7:0]        head_key;
    logic [HOLD_W-1:0] head_hold;
    logic              head_rel;

    assign wr.wr_ready = !reset_rtl_0 && (count_q < CNT_W'(DEPTH));
    assign push        = wr.wr_valid && wr.wr_ready;

    assign head_slot = mem_slot[rd_ptr];
    assign head_key  = mem_key[rd_ptr];
    assign head_hold = mem_hold[rd_ptr];
    assign head_rel  = mem_rel[rd_ptr];

    assign fifo_count               = count_q;
    assign busy                     = (state_q != ST_IDLE) || (count_q != '0);
    assign gpio_usb_keycode_0_tri_o = keys_q[31:0];
    assign gpio_usb_keycode_1_tri_o = keys_q[63:32];
    assign state_dbg                = state_q;

    // FIFO payload write; storage needs no reset since count gates reads
    always_ff @(posedge clk_100MHz) begin
        if (push) begin
            mem_slot[wr_ptr] <= wr.wr_slot;
            mem_key[wr_ptr]  <= wr.wr_keycode;
            mem_hold[wr_ptr] <= wr.wr_hold;
            mem_rel[wr_ptr]  <= wr.wr_release;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_100MHz) begin
        if (reset_rtl_0) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Playback FSM next state, counters and slot contents
    always_comb begin
        state_n = state_q;
        hold_n  = hold_q;
        gap_n   = gap_q;
        rel_n   = rel_q;
        keys_n  = keys_q;
        pop     = 1'b0;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run && (count_q != '0)) begin
                    pop = 1'b1;
                    if ({1'b0, head_slot} >= NUM_SLOTS_L) begin
                        err_set = 1'b1;
                    end else begin
                        keys_n[{head_slot, 3'b000} +: 8] = head_key;
                        hold_n  = (head_hold == '0) ? HOLD_W'(1) : head_hold;
                        rel_n   = head_rel;
                        state_n = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (run) begin
                    if (hold_q == HOLD_W'(1)) begin
                        if (rel_q) keys_n = '0;
                        gap_n   = GAP_LOAD;
                        state_n = ST_GAP;
                    end else begin
                        hold_n = hold_q - 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (run) begin
                    if (gap_q == GAP_W'(1)) begin
                        state_n = ST_IDLE;
                    end else begin
                        gap_n = gap_q - 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM/slot registers; key_int flags any change of the output words
    always_ff @(posedge clk_100MHz) begin
        if (reset_rtl_0) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            gap_q    <= '0;
            rel_q    <= 1'b0;
            keys_q   <= '0;
            key_int  <= 1'b0;
            err_slot <= 1'b0;
        end else begin
            state_q <= state_n;
            hold_q  <= hold_n;
            gap_q   <= gap_n;
            rel_q   <= rel_n;
            keys_q  <= keys_n;
            key_int <= (keys_n != keys_q);
            if (err_set) err_slot <= 1'b1;
        end
    end
endmodule
